// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the sign-extender.
// Owns PC, fetches over a req/ack handshake, holds the fetched word in Instr
// and computes the next PC from the sign-extended immediate fed back to it.
// Optional build macro PC_MISALIGN_CHECK_EN adds a sticky AddrErr output and
// forces PC word alignment.
module fetch_unit #(
    parameter int                   data_size = 32,
    parameter logic [data_size-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Stall,
    input  logic                 PCSrc,
    input  logic                 Jump,
    input  logic [data_size-1:0] SignImm,
    input  logic                 ImemAck,
    input  logic [data_size-1:0] ImemRdata,
    output logic                 ImemReq,
    output logic [data_size-1:0] ImemAddr,
    output logic [data_size-1:0] PC,
    output logic [data_size-1:0] PCPlus4,
    output logic [data_size-1:0] Instr,
    output logic                 InstrValid
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic                 AddrErr
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [data_size-1:0] next_pc;
    logic [data_size-1:0] pc_load;
    logic                 capture;
    logic                 advance;

    assign PCPlus4    = PC + 32'd4;
    assign ImemAddr   = PC;
    assign ImemReq    = (state == FETCH);
    assign InstrValid = (state == ISSUE);
    assign capture    = (state == FETCH) && ImemAck;
    assign advance    = (state == ISSUE) && !Stall;

    // Next PC: jump beats branch beats sequential. The branch offset shift
    // drops SignImm[31:30], which is the same as {SignImm[29:0], 2'b00}.
    always_comb begin
        next_pc = PCPlus4;
        if (Jump)
            next_pc = {PCPlus4[data_size-1:data_size-4], Instr[25:0], 2'b00};
        else if (PCSrc)
            next_pc = PCPlus4 + (SignImm << 2);
    end

`ifdef PC_MISALIGN_CHECK_EN
    // Misaligned targets are truncated to the word boundary.
    assign pc_load = {next_pc[data_size-1:2], 2'b00};
`else
    assign pc_load = next_pc;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; ack is only honoured in FETCH.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (ImemAck) state_nxt = ISSUE;
            ISSUE:   if (!Stall)  state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // PC and instruction register; Instr only changes on an ack capture so
    // the sign-extender sees a stable word through stalls and wait states.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PC    <= RESET_PC;
            Instr <= '0;
        end else begin
            if (capture) Instr <= ImemRdata;
            if (advance) PC    <= pc_load;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    // Sticky flag for a misaligned next PC, cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                          AddrErr <= 1'b0;
        else if (advance && |next_pc[1:0]) AddrErr <= 1'b1;
    end
`endif

endmodule
